odd_even_counter: RTL and testbench

Parametrised successor to the fixed 8-bit odd counter. Counts over odd values, even values, or all values, up or down, with synchronous load, enable and a registered wrap pulse. Used as a general stepping or index source in the counter library. Odd-mode behaviour from reset matches the legacy block: 1, 3, 5, ...

---
 rtl/odd_even_counter_pkg.sv | 39 +++
 rtl/odd_even_counter_next_val.sv | 99 +++++++++
 rtl/odd_even_counter.sv | 92 +++++++++
 tb/tb_odd_even_counter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/odd_even_counter_pkg.sv
// -----------------------------------------------------------------------------
// odd_even_counter_pkg
// Shared definitions for the odd/even/all stepping counter.
//   mode_t      : mode encodings carried on the 2-bit mode port
//   bounds_t    : min/max count limits, MAX_WIDTH bits wide
//   calc_bounds : min/max limits for a given counter width and mode
// -----------------------------------------------------------------------------
package odd_even_counter_pkg;

    typedef enum logic [1:0] {
        MODE_ODD  = 2'b00,
        MODE_EVEN = 2'b01,
        MODE_ALL  = 2'b10,
        MODE_HOLD = 2'b11
    } mode_t;

    localparam int unsigned MAX_WIDTH = 32;

    typedef struct packed {
        logic [MAX_WIDTH-1:0] min_v;
        logic [MAX_WIDTH-1:0] max_v;
    } bounds_t;

    // Bounds are computed at MAX_WIDTH; callers keep the low WIDTH bits.
    function automatic bounds_t calc_bounds(input int unsigned width, input mode_t mode);
        logic [63:0] full;
        bounds_t     b;
        full    = (64'd1 << width) - 64'd1;
        b.min_v = '0;
        b.max_v = full[MAX_WIDTH-1:0];
        case (mode)
            MODE_ODD:  b.min_v = 32'd1;
            MODE_EVEN: b.max_v = full[MAX_WIDTH-1:0] & ~32'd1;
            default:   ;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/odd_even_counter_next_val.sv
// -----------------------------------------------------------------------------
// counter_next_val
// Combinational next-value logic for odd_even_counter.
//   count_i   : current count
//   mode_i    : 00 odd, 01 even, 10 all, 11 hold
//   up_dn_i   : 1 up, 0 down
//   next_o    : value to load on an enabled edge
//   wrap_o    : the step crosses a bound and wraps
//   sat_o     : the step was clamped at a bound (saturating build only)
//   aligned_o : count parity matches the mode
// Macro ODD_EVEN_COUNTER_SATURATE_EN turns wrap-around into clamping.
// -----------------------------------------------------------------------------
module counter_next_val
    import odd_even_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic [1:0]       mode_i,
    input  logic             up_dn_i,
    output logic [WIDTH-1:0] next_o,
    output logic             wrap_o,
    output logic             sat_o,
    output logic             aligned_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

    mode_t            mode;
    bounds_t          bnd;
    logic [WIDTH-1:0] min_v;
    logic [WIDTH-1:0] max_v;
    logic [WIDTH-1:0] step;
    logic             unused_bnd;

    assign mode  = mode_t'(mode_i);
    assign bnd   = calc_bounds(WIDTH, mode);
    assign min_v = bnd.min_v[WIDTH-1:0];
    assign max_v = bnd.max_v[WIDTH-1:0];
    // Bits of the bounds above WIDTH carry no information.
    assign unused_bnd = ^bnd;
    assign step  = (mode == MODE_ALL) ? ONE : TWO;

    always_comb begin
        aligned_o = 1'b1;
        if (mode == MODE_ODD) begin
            aligned_o = count_i[0];
        end else if (mode == MODE_EVEN) begin
            aligned_o = ~count_i[0];
        end
    end

    always_comb begin
        next_o = count_i;
        wrap_o = 1'b0;
        sat_o  = 1'b0;
        if (mode != MODE_HOLD) begin
            if (!aligned_o) begin
                // Realign by one; only 0 -> all-ones or all-ones -> 0 can wrap.
                if (up_dn_i) begin
                    next_o = count_i + ONE;
                    wrap_o = &count_i;
                end else begin
                    next_o = count_i - ONE;
                    wrap_o = (count_i == '0);
                end
            end else if (up_dn_i) begin
                if (count_i == max_v) begin
                    next_o = min_v;
                    wrap_o = 1'b1;
                end else begin
                    next_o = count_i + step;
                end
            end else begin
                if (count_i == min_v) begin
                    next_o = max_v;
                    wrap_o = 1'b1;
                end else begin
                    next_o = count_i - step;
                end
            end
`ifdef ODD_EVEN_COUNTER_SATURATE_EN
            // Clamp instead of wrapping; a wrapping realign lands on the
            // bound nearest to the travel direction.
            if (wrap_o) begin
                wrap_o = 1'b0;
                sat_o  = 1'b1;
                if (aligned_o) begin
                    next_o = count_i;
                end else begin
                    next_o = up_dn_i ? max_v : min_v;
                end
            end
`endif
        end
    end

endmodule

// File: rtl/odd_even_counter.sv
// -----------------------------------------------------------------------------
// odd_even_counter
// Up/down counter stepping over odd, even or all values, with synchronous
// load (priority over enable) and a registered wrap pulse.
//   clk, rst  : clock, asynchronous active-high reset
//   en        : advance enable
//   mode      : 00 odd, 01 even, 10 all, 11 hold
//   up_dn     : 1 up, 0 down
//   load      : synchronous load of load_val (no parity correction)
//   count     : registered count
//   wrap      : registered one-cycle pulse when count shows a wrapped value
//   sat       : registered, count clamped at a bound (saturating build only)
//   aligned   : combinational, count parity matches mode
// Macro ODD_EVEN_COUNTER_SATURATE_EN: clamp at bounds, add sat, tie wrap to 0.
// -----------------------------------------------------------------------------
module odd_even_counter
    import odd_even_counter_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
`ifdef ODD_EVEN_COUNTER_SATURATE_EN
    output logic             sat,
`endif
    output logic             aligned
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             sat_q, sat_d;
    logic [WIDTH-1:0] next_val;
    logic             next_wrap;
    logic             next_sat;

    counter_next_val #(.WIDTH(WIDTH)) u_next (
        .count_i   (count_q),
        .mode_i    (mode),
        .up_dn_i   (up_dn),
        .next_o    (next_val),
        .wrap_o    (next_wrap),
        .sat_o     (next_sat),
        .aligned_o (aligned)
    );

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        sat_d   = 1'b0;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = next_val;
            wrap_d  = next_wrap;
            sat_d   = next_sat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= RESET_VAL;
            wrap_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            sat_q   <= sat_d;
        end
    end

    assign count = count_q;

`ifdef ODD_EVEN_COUNTER_SATURATE_EN
    assign wrap = 1'b0;
    assign sat  = sat_q;
    logic unused_wrap;
    assign unused_wrap = wrap_q;
`else
    assign wrap = wrap_q;
    logic unused_sat;
    assign unused_sat = sat_q;
`endif

endmodule

// File: tb/tb_odd_even_counter.sv
module tb_odd_even_counter;

`ifdef ODD_EVEN_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       load = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] load_val = 8'h00;

    logic [7:0] count8;
    logic       wrap8, aligned8;
    logic [3:0] count4;
    logic       wrap4, aligned4;
`ifdef ODD_EVEN_COUNTER_SATURATE_EN
    logic       sat8, sat4;
`endif

    int checks = 0;
    int failures = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    odd_even_counter #(.WIDTH(8), .RESET_VAL(8'h01)) u_dut8 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .up_dn(up_dn),
        .load(load), .load_val(load_val), .count(count8), .wrap(wrap8),
`ifdef ODD_EVEN_COUNTER_SATURATE_EN
        .sat(sat8),
`endif
        .aligned(aligned8)
    );

    odd_even_counter #(.WIDTH(4), .RESET_VAL(4'h1)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .up_dn(up_dn),
        .load(load), .load_val(load_val[3:0]), .count(count4), .wrap(wrap4),
`ifdef ODD_EVEN_COUNTER_SATURATE_EN
        .sat(sat4),
`endif
        .aligned(aligned4)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int wof(input int i);
        return (i == 0) ? 8 : 4;
    endfunction

    function automatic bit model_aligned(input int c, input int md);
        if (md >= 2) return 1'b1;
        return ((c % 2) == 1) == (md == 0);
    endfunction

    function automatic void model_step(input int w, input int c, input int md, input bit up,
                                       output int nc, output bit nw, output bit ns);
        int modv, lo, hi, stp, t;
        modv = 1 << w;
        nc = c; nw = 1'b0; ns = 1'b0;
        if (md == 3) return;
        lo  = (md == 0) ? 1 : 0;
        hi  = (md == 1) ? modv - 2 : modv - 1;
        stp = (md == 2) ? 1 : 2;
        if (!model_aligned(c, md)) begin
            t = up ? c + 1 : c - 1;
            if (t < 0 || t >= modv) begin
                if (SAT) begin nc = up ? hi : lo; ns = 1'b1; end
                else begin nc = (t + modv) % modv; nw = 1'b1; end
            end else begin
                nc = t;
            end
        end else begin
            t = up ? c + stp : c - stp;
            if (t > hi || t < lo) begin
                if (SAT) begin nc = c; ns = 1'b1; end
                else begin nc = up ? lo : hi; nw = 1'b1; end
            end else begin
                nc = t;
            end
        end
    endfunction

    int m_cnt [2];
    bit m_wrap[2];
    bit m_sat [2];
    int m_nc;
    bit m_nw, m_ns;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_cnt[i] = 1; m_wrap[i] = 1'b0; m_sat[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (load) begin
                    m_cnt[i] = int'(load_val) % (1 << wof(i));
                    m_wrap[i] = 1'b0; m_sat[i] = 1'b0;
                end else if (en) begin
                    model_step(wof(i), m_cnt[i], int'(mode), up_dn, m_nc, m_nw, m_ns);
                    m_cnt[i] = m_nc; m_wrap[i] = m_nw; m_sat[i] = m_ns;
                end else begin
                    m_wrap[i] = 1'b0; m_sat[i] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_cnt8",  int'(count8),   m_cnt[0]);
            check("model_wrap8", int'(wrap8),    SAT ? 0 : int'(m_wrap[0]));
            check("model_alg8",  int'(aligned8), int'(model_aligned(m_cnt[0], int'(mode))));
            check("model_cnt4",  int'(count4),   m_cnt[1]);
            check("model_wrap4", int'(wrap4),    SAT ? 0 : int'(m_wrap[1]));
            check("model_alg4",  int'(aligned4), int'(model_aligned(m_cnt[1], int'(mode))));
`ifdef ODD_EVEN_COUNTER_SATURATE_EN
            check("model_sat8",  int'(sat8),     int'(m_sat[0]));
            check("model_sat4",  int'(sat4),     int'(m_sat[1]));
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input bit e, input bit ld, input logic [1:0] md, input bit up,
                         input logic [7:0] lv);
        en = e; load = ld; mode = md; up_dn = up; load_val = lv;
        @(posedge clk); #1;
    endtask

    initial begin
        #2 rst = 1'b1;
        @(posedge clk); #1;
        chk_on = 1'b1;
        check("rst_cnt8", int'(count8), 8'h01);
        check("rst_wrap8", int'(wrap8), 0);
        check("rst_cnt4", int'(count4), 4'h1);
        rst = 1'b0;

        // Legacy odd sequence from reset
        drive(1, 0, 2'b00, 1, 8'h00);
        check("legacy_first", int'(count8), 8'h03);
        drive(1, 0, 2'b00, 1, 8'h00);
        drive(1, 0, 2'b00, 1, 8'h00);
        check("legacy_third", int'(count8), 8'h07);

        // Odd-mode wrap at the top
        drive(0, 1, 2'b00, 1, 8'hFD);
        check("load_fd", int'(count8), 8'hFD);
        drive(1, 0, 2'b00, 1, 8'h00);
        check("odd_max", int'(count8), 8'hFF);
        check("odd_max_wrap", int'(wrap8), 0);
        drive(1, 0, 2'b00, 1, 8'h00);
        check("odd_wrap_cnt", int'(count8), SAT ? 8'hFF : 8'h01);
        check("odd_wrap_pulse", int'(wrap8), SAT ? 0 : 1);
        drive(0, 0, 2'b00, 1, 8'h00);
        check("odd_wrap_drop", int'(wrap8), 0);
        check("idle_hold", int'(count8), SAT ? 8'hFF : 8'h01);

        // Even-mode realign up, then down
        drive(0, 1, 2'b01, 1, 8'h05);
        check("misaligned", int'(aligned8), 0);
        drive(1, 0, 2'b01, 1, 8'h00);
        check("realign_up", int'(count8), 8'h06);
        check("realign_up_alg", int'(aligned8), 1);
        drive(1, 0, 2'b01, 1, 8'h00);
        check("even_up", int'(count8), 8'h08);
        drive(0, 1, 2'b01, 0, 8'h05);
        drive(1, 0, 2'b01, 0, 8'h00);
        check("realign_dn", int'(count8), 8'h04);
        drive(1, 0, 2'b01, 0, 8'h00);
        check("even_dn", int'(count8), 8'h02);

        // Priority and hold
        drive(1, 1, 2'b00, 1, 8'h2A);
        check("load_over_en", int'(count8), 8'h2A);
        drive(1, 0, 2'b11, 1, 8'h00);
        check("hold_mode_cnt", int'(count8), 8'h2A);
        check("hold_mode_wrap", int'(wrap8), 0);
        drive(0, 0, 2'b00, 1, 8'h00);
        check("en_low_hold", int'(count8), 8'h2A);

        // Even mode down from 0
        drive(0, 1, 2'b01, 0, 8'h00);
        drive(1, 0, 2'b01, 0, 8'h00);
        check("even_dn_wrap", int'(count8), SAT ? 8'h00 : 8'hFE);
        check("even_dn_pulse", int'(wrap8), SAT ? 0 : 1);
        check("even_dn_wrap4", int'(count4), SAT ? 4'h0 : 4'hE);

        // All mode up from 4'hF on the narrow instance
        drive(0, 1, 2'b10, 1, 8'h0F);
        drive(1, 0, 2'b10, 1, 8'h00);
        check("all_up_wide", int'(count8), 8'h10);
        check("all_up_wrap4", int'(count4), SAT ? 4'hF : 4'h0);
        check("all_up_pulse4", int'(wrap4), SAT ? 0 : 1);

        // Odd mode down from 0 (realign that wraps)
        drive(0, 1, 2'b00, 0, 8'h00);
        drive(1, 0, 2'b00, 0, 8'h00);
        check("odd_dn_from0", int'(count8), SAT ? 8'h01 : 8'hFF);
        check("odd_dn_pulse", int'(wrap8), SAT ? 0 : 1);
        for (int k = 0; k < 3; k++) drive(1, 0, 2'b00, 0, 8'h00);

        // Even mode up from all-ones (realign that wraps)
        drive(0, 1, 2'b01, 1, 8'hFF);
        drive(1, 0, 2'b01, 1, 8'h00);
        check("even_up_fromff", int'(count8), SAT ? 8'hFE : 8'h00);

        // All mode down across zero, then mode/direction changes
        drive(0, 1, 2'b10, 0, 8'h02);
        for (int k = 0; k < 4; k++) drive(1, 0, 2'b10, 0, 8'h00);
        drive(1, 0, 2'b00, 1, 8'h00);
        drive(1, 0, 2'b01, 0, 8'h00);
        drive(1, 0, 2'b01, 0, 8'h00);

`ifdef ODD_EVEN_COUNTER_SATURATE_EN
        drive(0, 1, 2'b00, 1, 8'hFF);
        drive(1, 0, 2'b00, 1, 8'h00);
        check("sat_hold", int'(count8), 8'hFF);
        check("sat_flag", int'(sat8), 1);
        check("sat_nowrap", int'(wrap8), 0);
`endif

        // Asynchronous reset between edges
        drive(1, 0, 2'b10, 1, 8'h00);
        drive(1, 0, 2'b10, 1, 8'h00);
        #1 rst = 1'b1;
        #1;
        check("async_rst_cnt8", int'(count8), 8'h01);
        check("async_rst_wrap8", int'(wrap8), 0);
        check("async_rst_cnt4", int'(count4), 4'h1);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_step", int'(count8), 8'h02);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
